// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between instruction fetch and
// load/store. One access in flight at a time; load/store normally wins, and a
// starvation counter forces a fetch grant after STARVE_LIMIT lost rounds.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // fetch port
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    input  logic                    if_flush,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    // load/store port
    input  logic                    ls_req,
    input  logic                    ls_we,
    input  logic [DATA_WIDTH/8-1:0] ls_be,
    input  logic [ADDR_WIDTH-1:0]   ls_addr,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    output logic                    ls_gnt,
    output logic                    ls_rvalid,
    output logic [DATA_WIDTH-1:0]   ls_rdata,
    // memory port
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-3:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic [WW-1:0] wait_cnt_q;
    logic          owner_if_q;   // 1 = current access belongs to fetch
    logic          we_q;         // current access is a store
    logic          drop_q;       // fetch result squashed by a flush

    logic if_elig;
    logic ls_elig;
    logic pick_if;

    // Word-offset address bits are not used by a word-wide memory.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{if_addr[1:0], ls_addr[1:0]};

    // Arbitration decision and the starvation counter value it would produce.
    always_comb begin
        if_elig  = if_req && !if_flush;
        ls_elig  = ls_req;
        pick_if  = if_elig && (!ls_elig || (starve_q == STARVE_MAX));
        starve_d = '0;
        if (if_elig && ls_elig && !pick_if) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
        end
    end

    // Sequencer FSM; every output is a flop updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            wait_cnt_q <= '0;
            owner_if_q <= 1'b0;
            we_q       <= 1'b0;
            drop_q     <= 1'b0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            ls_gnt     <= 1'b0;
            ls_rvalid  <= 1'b0;
            ls_rdata   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            // Pulses default low; data-carrying outputs hold.
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            case (state_q)
                // The edge ending RESP doubles as an arbitration edge so that
                // back-to-back accesses take MEM_LATENCY+2 cycles each.
                IDLE, RESP: begin
                    if (if_elig || ls_elig) begin
                        starve_q   <= starve_d;
                        owner_if_q <= pick_if;
                        drop_q     <= 1'b0;
                        mem_en     <= 1'b1;
                        state_q    <= ISSUE;
                        if (pick_if) begin
                            if_gnt   <= 1'b1;
                            we_q     <= 1'b0;
                            mem_be   <= '1;
                            mem_addr <= if_addr[ADDR_WIDTH-1:2];
                        end else begin
                            ls_gnt    <= 1'b1;
                            we_q      <= ls_we;
                            mem_we    <= ls_we;
                            mem_be    <= ls_we ? ls_be : '1;
                            mem_addr  <= ls_addr[ADDR_WIDTH-1:2];
                            mem_wdata <= ls_wdata;
                        end
                    end else begin
                        starve_q <= '0;
                        state_q  <= IDLE;
                    end
                end
                ISSUE: begin
                    wait_cnt_q <= WAIT_LAST;
                    state_q    <= WAIT;
                    if (owner_if_q && if_flush) begin
                        drop_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (owner_if_q && if_flush) begin
                        drop_q <= 1'b1;
                    end
                    if (wait_cnt_q == '0) begin
                        state_q <= RESP;
                        if (owner_if_q) begin
                            // A flush in this final cycle also squashes the result.
                            if (!(drop_q || if_flush)) begin
                                if_rvalid <= 1'b1;
                                if_rdata  <= mem_rdata;
                            end
                        end else begin
                            ls_rvalid <= 1'b1;
                            ls_rdata  <= we_q ? '0 : mem_rdata;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
